// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that shares one iterative CORDIC core among N_REQ requesters.
// Optional WAIT timeout is compiled in with `define CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] z_i,
  output logic                    start_cordic_o,
  output logic [DATA_W-1:0]       z_o,
  input  logic                    done_tick_cordic_i,
  input  logic [DATA_W-1:0]       cos_i,
  input  logic [DATA_W-1:0]       sin_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic [DATA_W-1:0]       cos_o,
  output logic [DATA_W-1:0]       sin_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("cordic_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("cordic_arbiter: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_found;
  logic [N_REQ-1:0] grant_onehot;
  int               cand;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign err_o = 1'b0;
`endif

  // Search starts just after the last winner so the previous grantee has lowest priority.
  always_comb begin
    rr_winner = last_grant;
    rr_found  = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_grant) + i) % N_REQ;
      if (!rr_found && req_i[cand[IDX_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(N_REQ - 1);
      grant_idx      <= '0;
      win_idx        <= '0;
      z_o            <= '0;
      cos_o          <= '0;
      sin_o          <= '0;
      start_cordic_o <= 1'b0;
      ack_o          <= '0;
      busy_o         <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      err_o          <= 1'b0;
      wait_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rr_found) begin
            win_idx <= rr_winner;
            busy_o  <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          grant_idx      <= win_idx;
          last_grant     <= win_idx;
          z_o            <= z_i[int'(win_idx)*DATA_W +: DATA_W];
          start_cordic_o <= 1'b1;
          state          <= START;
        end
        START: begin
          start_cordic_o <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
          wait_cnt       <= '0;
`endif
          state          <= WAIT;
        end
        // A real completion wins over a timeout landing in the same cycle.
        WAIT: begin
          if (done_tick_cordic_i) begin
            cos_o <= cos_i;
            sin_o <= sin_i;
            ack_o <= grant_onehot;
            state <= RESP;
          end
`ifdef CORDIC_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            ack_o <= grant_onehot;
            err_o <= 1'b1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          ack_o  <= '0;
          busy_o <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
          err_o  <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: begin
          start_cordic_o <= 1'b0;
          ack_o          <= '0;
          busy_o         <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
          err_o          <= 1'b0;
`endif
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: the bench plays the CORDIC core and the requesters.
module tb_cordic_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] z_i;
  logic           start_cordic_o;
  logic [W-1:0]   z_o;
  logic           done_tick;
  logic [W-1:0]   cos_i, sin_i;
  logic [N-1:0]   ack_o;
  logic [W-1:0]   cos_o, sin_o;
  logic           err_o, busy_o;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic         err;
  } exp_t;

  exp_t         expQ[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] zTab [N] = '{16'h0800, 16'h1000, 16'h2000, 16'h3000};
  logic [W-1:0] lastCos = '0;
  logic [W-1:0] lastSin = '0;
  int           cyc;

  cordic_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(64)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_i              (req_i),
    .z_i                (z_i),
    .start_cordic_o     (start_cordic_o),
    .z_o                (z_o),
    .done_tick_cordic_i (done_tick),
    .cos_i              (cos_i),
    .sin_i              (sin_i),
    .ack_o              (ack_o),
    .cos_o              (cos_o),
    .sin_o              (sin_o),
    .err_o              (err_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every ack the DUT shows must match the oldest expected response.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_i && ack_o != '0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_ack", 64'(ack_o), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_ack", 64'(ack_o), 64'(e.ack));
        checkOutput("sb_cos", 64'(cos_o), 64'(e.c));
        checkOutput("sb_sin", 64'(sin_o), 64'(e.s));
        checkOutput("sb_err", 64'(err_o), 64'(e.err));
      end
    end
  end

  task automatic doReset();
    rst_i     = 1'b1;
    req_i     = '0;
    done_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic waitStart(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (start_cordic_o) begin
        n = i;
        break;
      end
    end
    if (n == 0) checkOutput("start_seen", 64'd0, 64'd1);
  endtask

  // Entered on the negedge where start is visible; plays the core and pulses done after 'delay' cycles.
  task automatic applyStimulus(input int idx, input int delay, input logic [W-1:0] c,
                               input logic [W-1:0] s, input logic [N-1:0] reqDuring,
                               input logic [N-1:0] reqAfterAck);
    exp_t         e;
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    checkOutput("z_o_grant", 64'(z_o), 64'(zTab[idx]));
    @(negedge clk);
    checkOutput("start_one_cycle", 64'(start_cordic_o), 64'd0);
    req_i = reqDuring;
    for (int i = 1; i < delay; i++) @(negedge clk);
    e.ack = oh; e.c = c; e.s = s; e.err = 1'b0;
    expQ.push_back(e);
    done_tick = 1'b1;
    cos_i     = c;
    sin_i     = s;
    lastCos   = c;
    lastSin   = s;
    @(negedge clk);
    done_tick = 1'b0;
    cos_i     = 16'hdead;
    sin_i     = 16'hbeef;
    checkOutput("ack_latency", 64'(ack_o), 64'(oh));
    req_i = reqAfterAck;
    @(negedge clk);
    checkOutput("ack_one_cycle", 64'(ack_o), 64'd0);
  endtask

  initial begin : watchdog
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_i     = 1'b1;
    req_i     = '0;
    done_tick = 1'b0;
    cos_i     = '0;
    sin_i     = '0;
    z_i       = {zTab[3], zTab[2], zTab[1], zTab[0]};
    repeat (3) @(negedge clk);
    checkOutput("rst_outputs", 64'({start_cordic_o, z_o, ack_o, cos_o, sin_o, err_o, busy_o}), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Single request from requester 2, core completes 18 cycles after start.
    req_i = 4'b0100;
    @(negedge clk);
    checkOutput("busy_after_req", 64'(busy_o), 64'd1);
    checkOutput("no_early_start", 64'(start_cordic_o), 64'd0);
    @(negedge clk);
    checkOutput("start_at_k2", 64'(start_cordic_o), 64'd1);
    applyStimulus(2, 18, 16'h7ff0, 16'h0123, 4'b0100, 4'b0000);
    checkOutput("cos_hold", 64'(cos_o), 64'h7ff0);
    checkOutput("sin_hold", 64'(sin_o), 64'h0123);
    checkOutput("busy_idle", 64'(busy_o), 64'd0);
    checkOutput("z_o_hold", 64'(z_o), 64'h2000);

    // All requests held from reset: order 0,1,2,3,0.
    doReset();
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      waitStart(cyc);
      applyStimulus(k % 4, 3 + k, 16'h1000 + 16'(k), 16'h2000 + 16'(k), 4'b1111,
                    (k == 4) ? 4'b0000 : 4'b1111);
    end

    // Requester 1 drops its request while the core runs, then a spurious done in IDLE.
    req_i = 4'b0010;
    waitStart(cyc);
    applyStimulus(1, 5, 16'h0aaa, 16'h0555, 4'b0000, 4'b0000);
    done_tick = 1'b1;
    cos_i     = 16'h1111;
    sin_i     = 16'h2222;
    @(negedge clk);
    done_tick = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("spurious_no_ack", 64'(ack_o), 64'd0);
    checkOutput("spurious_idle", 64'(busy_o), 64'd0);
    checkOutput("spurious_cos", 64'(cos_o), 64'h0aaa);

    // Reset while waiting on the core, then a late done tick.
    req_i = 4'b0001;
    waitStart(cyc);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst", 64'({start_cordic_o, z_o, ack_o, cos_o, sin_o, err_o, busy_o}), 64'd0);
    req_i = '0;
    @(negedge clk);
    rst_i     = 1'b0;
    done_tick = 1'b1;
    @(negedge clk);
    done_tick = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("late_done_no_ack", 64'(ack_o), 64'd0);
    checkOutput("late_done_idle", 64'(busy_o), 64'd0);
    lastCos = '0;
    lastSin = '0;
    req_i = 4'b1000;
    waitStart(cyc);
    applyStimulus(3, 1, 16'h0321, 16'h0654, 4'b1000, 4'b0000);

    // Requester 0 re-requests during its ack while 3 waits: 3 is served before 0.
    req_i = 4'b0001;
    waitStart(cyc);
    applyStimulus(0, 2, 16'h4001, 16'h5001, 4'b1001, 4'b1001);
    waitStart(cyc);
    applyStimulus(3, 2, 16'h4003, 16'h5003, 4'b1001, 4'b0001);
    waitStart(cyc);
    applyStimulus(0, 2, 16'h4000, 16'h5000, 4'b0001, 4'b0000);

`ifdef CORDIC_ARB_TIMEOUT_EN
    // Core never answers requester 2; requester 1 is queued behind it.
    begin
      exp_t e;
      int   n;
      req_i = 4'b0100;
      waitStart(cyc);
      checkOutput("to_z_o", 64'(z_o), 64'(zTab[2]));
      e.ack = 4'b0100; e.c = lastCos; e.s = lastSin; e.err = 1'b1;
      expQ.push_back(e);
      req_i = 4'b0110;
      n = 0;
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (ack_o != '0) begin
          n = i;
          break;
        end
      end
      checkOutput("timeout_cycles", 64'(n), 64'd65);
      req_i = 4'b0010;
      waitStart(cyc);
      applyStimulus(1, 4, 16'h0bbb, 16'h0ccc, 4'b0010, 4'b0000);
    end
`endif

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
